des_cbc_ctrl: RTL and testbench
===============================

DES_CBC_CTRL -- requirements
Module: des_cbc_ctrl

Interface
REQ-001 SHALL have parameter DES_W, default 64, block/key width.
REQ-002 SHALL have port i_Clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port i_Rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_fInit  input  1  load key, IV and mode (1-cycle strobe).
REQ-005 SHALL have port i_fDec  input  1  mode, sampled with i_fInit: 0=CBC encrypt, 1=CBC decrypt.
REQ-006 SHALL have port i_Key  input  64  DES key, sampled with i_fInit.
REQ-007 SHALL have port i_IV  input  64  initial chaining value, sampled with i_fInit.
REQ-008 SHALL have ports i_fInValid input 1, o_fInReady output 1, i_InBlk input 64: input block handshake.
REQ-009 SHALL have ports o_fOutValid output 1, i_fOutReady input 1, o_OutBlk output 64: result block handshake.
REQ-010 SHALL have ports o_Des_fStart output 1, o_Des_fDec output 1, o_Des_Key output 64, o_Des_Text output 64: requests to the DES core.
REQ-011 SHALL have ports i_Des_fDone input 1, i_Des_Text input 64: DES core result; valid only in the i_Des_fDone cycle.
REQ-012 SHALL have port o_fBusy  output 1  high in every state other than S_RDY.

Function
REQ-013 SHALL implement FSM states S_RDY, S_START, S_WAIT, S_OUT; reset state S_RDY.
REQ-014 SHALL hold registers: KeyR, ChainR, ModeR, CtSaveR, InR, OutR, and flag fKeyVld (cleared by reset, set by an accepted i_fInit).
REQ-015 SHALL accept i_fInit only in S_RDY: KeyR<=i_Key, ChainR<=i_IV, ModeR<=i_fDec, fKeyVld<=1; i_fInit in any other state is ignored.
REQ-016 SHALL drive o_fInReady = (state==S_RDY) && fKeyVld && !i_fInit, so init takes priority and blocks input that cycle.
REQ-017 SHALL, on i_fInValid && o_fInReady: encrypt -> InR<=i_InBlk^ChainR; decrypt -> InR<=i_InBlk and CtSaveR<=i_InBlk; go to S_START.
REQ-018 SHALL, in S_START, assert o_Des_fStart for exactly one cycle, then go to S_WAIT; o_Des_Text=InR, o_Des_Key=KeyR, o_Des_fDec=ModeR are held constant from S_START until leaving S_WAIT.
REQ-019 SHALL, in S_WAIT on i_Des_fDone: encrypt -> OutR<=i_Des_Text and ChainR<=i_Des_Text; decrypt -> OutR<=i_Des_Text^ChainR and ChainR<=CtSaveR; go to S_OUT.
REQ-020 SHALL ignore i_Des_fDone outside S_WAIT.
REQ-021 SHALL assert o_fOutValid only in S_OUT, with o_OutBlk=OutR stable while o_fOutValid && !i_fOutReady; on i_fOutReady go to S_RDY.
REQ-022 SHALL give a latency, from input acceptance edge, of 1 cycle to o_Des_fStart, and 1 cycle from the i_Des_fDone edge to o_fOutValid.
REQ-023 SHALL accept the next input no earlier than the cycle after the output handshake, giving at most one block in flight.
REQ-024 SHALL persist ChainR across blocks until the next accepted i_fInit; re-init between blocks restarts the chain.
REQ-025 SHALL perform all XORs at full 64-bit width with no truncation.

Reset
REQ-026 SHALL, on i_Rst low, immediately set state=S_RDY, fKeyVld=0, and all data registers to 0.
REQ-027 SHALL, on i_Rst low, immediately set o_fInReady=0, o_fOutValid=0, o_Des_fStart=0, o_fBusy=0, o_OutBlk=0, o_Des_Text=0, o_Des_Key=0, o_Des_fDec=0.
REQ-028 SHALL, when reset is asserted mid-block (S_START/S_WAIT/S_OUT), discard the block, and SHALL require a new i_fInit after reset before any input is accepted.

Structure
REQ-029 SHALL place the FSM state encoding (2-bit) and the DES block/key width constant (64) in the shared DES package.
REQ-030 SHALL instantiate no sub-module; the DES core connects at the level above through the o_Des_*/i_Des_* ports.

Verification
REQ-031 SHALL cover: init key=133457799BBCDFF1, IV=0, enc; block 0123456789ABCDEF -> core sees 0123456789ABCDEF; out 85E813540F0AB405.
REQ-032 SHALL cover: init same key, IV=0123456789ABCDEF, enc; block 0000000000000000 -> core sees 0123456789ABCDEF; out 85E813540F0AB405; ChainR=85E813540F0AB405.
REQ-033 SHALL cover: init same key, IV=0123456789ABCDEF, dec; block 85E813540F0AB405 -> out 0000000000000000; ChainR=85E813540F0AB405.
REQ-034 SHALL cover: 4-block enc stream with i_fOutReady held low 5 cycles on block 2 -> o_OutBlk stable, o_fInReady low, outputs match a software CBC model.
REQ-035 SHALL cover: i_fInit with i_fInValid in S_RDY -> init applied, block not accepted; i_fInit in S_WAIT -> ignored; stray i_Des_fDone in S_RDY -> no output.
REQ-036 SHALL cover: reset pulse during S_WAIT -> all outputs 0 next cycle, o_fInReady stays 0 until i_fInit.

Source files
------------

// File: rtl/des_cbc_pkg.sv
// Shared DES definitions: block/key width and the CBC controller state encoding.
package des_cbc_pkg;

    localparam int DES_W_C = 64;

    typedef enum logic [1:0] {
        S_RDY   = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } cbc_state_t;

endpackage

// File: rtl/des_cbc_ctrl.sv
// CBC chaining controller around an external DES core: one block in flight,
// chaining value kept across blocks until the next init.
module des_cbc_ctrl
    import des_cbc_pkg::*;
#(
    parameter int DES_W = DES_W_C
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_fInit,
    input  logic             i_fDec,
    input  logic [DES_W-1:0] i_Key,
    input  logic [DES_W-1:0] i_IV,
    input  logic             i_fInValid,
    output logic             o_fInReady,
    input  logic [DES_W-1:0] i_InBlk,
    output logic             o_fOutValid,
    input  logic             i_fOutReady,
    output logic [DES_W-1:0] o_OutBlk,
    output logic             o_Des_fStart,
    output logic             o_Des_fDec,
    output logic [DES_W-1:0] o_Des_Key,
    output logic [DES_W-1:0] o_Des_Text,
    input  logic             i_Des_fDone,
    input  logic [DES_W-1:0] i_Des_Text,
    output logic             o_fBusy
);

    cbc_state_t       state_r;
    logic [DES_W-1:0] key_r;
    logic [DES_W-1:0] chain_r;
    logic [DES_W-1:0] ct_save_r;
    logic [DES_W-1:0] in_r;
    logic [DES_W-1:0] out_r;
    logic             mode_r;
    logic             key_vld_r;

    // Control and data path; the DES request fields only change on block acceptance,
    // so they stay constant throughout START and WAIT.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_r   <= S_RDY;
            key_r     <= '0;
            chain_r   <= '0;
            ct_save_r <= '0;
            in_r      <= '0;
            out_r     <= '0;
            mode_r    <= 1'b0;
            key_vld_r <= 1'b0;
        end else begin
            case (state_r)
                S_RDY: begin
                    if (i_fInit) begin
                        key_r     <= i_Key;
                        chain_r   <= i_IV;
                        mode_r    <= i_fDec;
                        key_vld_r <= 1'b1;
                    end else if (i_fInValid && key_vld_r) begin
                        // Decrypt keeps the ciphertext: it becomes the next chaining value.
                        if (mode_r) begin
                            in_r      <= i_InBlk;
                            ct_save_r <= i_InBlk;
                        end else begin
                            in_r      <= i_InBlk ^ chain_r;
                        end
                        state_r <= S_START;
                    end
                end
                S_START: begin
                    state_r <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_Des_fDone) begin
                        if (mode_r) begin
                            out_r   <= i_Des_Text ^ chain_r;
                            chain_r <= ct_save_r;
                        end else begin
                            out_r   <= i_Des_Text;
                            chain_r <= i_Des_Text;
                        end
                        state_r <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (i_fOutReady) begin
                        state_r <= S_RDY;
                    end
                end
                default: begin
                    state_r <= S_RDY;
                end
            endcase
        end
    end

    assign o_fInReady   = (state_r == S_RDY) && key_vld_r && !i_fInit;
    assign o_fOutValid  = (state_r == S_OUT);
    assign o_Des_fStart = (state_r == S_START);
    assign o_fBusy      = (state_r != S_RDY);
    assign o_OutBlk     = out_r;
    assign o_Des_Text   = in_r;
    assign o_Des_Key    = key_r;
    assign o_Des_fDec   = mode_r;

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// Directed bench for des_cbc_ctrl; the DES core is replaced by a small reference
// model that knows the classic test pair and a reversible stand-in cipher otherwise.
module tb_des_cbc_ctrl;

    localparam logic [63:0] K_C   = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] PT_C  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] CT_C  = 64'h85E8_1354_0F0A_B405;

    logic        i_Clk;
    logic        i_Rst;
    logic        i_fInit;
    logic        i_fDec;
    logic [63:0] i_Key;
    logic [63:0] i_IV;
    logic        i_fInValid;
    logic        o_fInReady;
    logic [63:0] i_InBlk;
    logic        o_fOutValid;
    logic        i_fOutReady;
    logic [63:0] o_OutBlk;
    logic        o_Des_fStart;
    logic        o_Des_fDec;
    logic [63:0] o_Des_Key;
    logic [63:0] o_Des_Text;
    logic        i_Des_fDone;
    logic [63:0] i_Des_Text;
    logic        o_fBusy;

    int checks = 0;
    int errors = 0;

    des_cbc_ctrl #(.DES_W(64)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_fInit(i_fInit), .i_fDec(i_fDec),
        .i_Key(i_Key), .i_IV(i_IV), .i_fInValid(i_fInValid), .o_fInReady(o_fInReady),
        .i_InBlk(i_InBlk), .o_fOutValid(o_fOutValid), .i_fOutReady(i_fOutReady),
        .o_OutBlk(o_OutBlk), .o_Des_fStart(o_Des_fStart), .o_Des_fDec(o_Des_fDec),
        .o_Des_Key(o_Des_Key), .o_Des_Text(o_Des_Text), .i_Des_fDone(i_Des_fDone),
        .i_Des_Text(i_Des_Text), .o_fBusy(o_fBusy)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic        dec;
        logic [63:0] iv;
        logic [63:0] blk;
        logic [63:0] core_in;
        logic [63:0] out;
        logic [63:0] chain;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [63:0] des_model(input logic dec, input logic [63:0] key,
                                              input logic [63:0] x);
        logic [63:0] y;
        if (!dec && key == K_C && x == PT_C) return CT_C;
        if (dec && key == K_C && x == CT_C) return PT_C;
        if (!dec) begin
            y = {x[31:0], x[63:32]} ^ key;
        end else begin
            y = x ^ key;
            y = {y[31:0], y[63:32]};
        end
        return y;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_Clk);
        #2;
    endtask

    task automatic do_init(input logic dec, input logic [63:0] key, input logic [63:0] iv);
        i_fInit = 1'b1;
        i_fDec  = dec;
        i_Key   = key;
        i_IV    = iv;
        step();
        i_fInit = 1'b0;
    endtask

    task automatic run_block(input logic [63:0] blk, input logic dec, input logic [63:0] key,
                             input logic [63:0] exp_core, input logic [63:0] exp_out,
                             input int stall, input bit init_in_wait);
        logic [63:0] core_res;
        core_res   = des_model(dec, key, exp_core);
        i_InBlk    = blk;
        i_fInValid = 1'b1;
        #1;
        chk("in_ready_rdy", o_fInReady, 64'd1);
        step();
        i_fInValid = 1'b0;
        chk("des_start", o_Des_fStart, 64'd1);
        chk("des_text", o_Des_Text, exp_core);
        chk("des_key", o_Des_Key, key);
        chk("des_dec", o_Des_fDec, {63'd0, dec});
        chk("busy_start", o_fBusy, 64'd1);
        chk("in_ready_start", o_fInReady, 64'd0);
        step();
        chk("start_once", o_Des_fStart, 64'd0);
        chk("no_out_wait", o_fOutValid, 64'd0);
        if (init_in_wait) begin
            i_fInit = 1'b1;
            i_Key   = ~key;
            i_IV    = 64'hFFFF_FFFF_FFFF_FFFF;
            i_fDec  = ~dec;
        end
        step();
        i_fInit = 1'b0;
        chk("des_key_hold", o_Des_Key, key);
        chk("des_text_hold", o_Des_Text, exp_core);
        i_Des_fDone = 1'b1;
        i_Des_Text  = core_res;
        step();
        i_Des_fDone = 1'b0;
        i_Des_Text  = 64'hDEAD_BEEF_DEAD_BEEF;
        chk("out_valid", o_fOutValid, 64'd1);
        chk("out_blk", o_OutBlk, exp_out);
        for (int s = 0; s < stall; s++) begin
            step();
            chk("stall_valid", o_fOutValid, 64'd1);
            chk("stall_blk", o_OutBlk, exp_out);
            chk("stall_in_ready", o_fInReady, 64'd0);
        end
        i_fOutReady = 1'b1;
        step();
        i_fOutReady = 1'b0;
        chk("out_done", o_fOutValid, 64'd0);
        chk("busy_done", o_fBusy, 64'd0);
    endtask

    initial begin
        logic [63:0] chain;
        logic [63:0] ci;
        logic [63:0] ct;
        logic [63:0] blks[4];

        vecs[0] = '{1'b0, 64'd0, PT_C, PT_C, CT_C, CT_C};
        vecs[1] = '{1'b0, PT_C, 64'd0, PT_C, CT_C, CT_C};
        vecs[2] = '{1'b1, PT_C, CT_C, CT_C, 64'd0, CT_C};
        vecs[3] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0,
                    64'hEDCB_A987_6543_210F, 64'h0000_0000_0000_0000, 64'h0};
        vecs[4] = '{1'b1, 64'hA5A5_A5A5_A5A5_A5A5, 64'hC3C3_0F0F_5A5A_9696,
                    64'hC3C3_0F0F_5A5A_9696, 64'h0, 64'hC3C3_0F0F_5A5A_9696};
        vecs[3].out   = des_model(1'b0, K_C, vecs[3].core_in);
        vecs[3].chain = vecs[3].out;
        vecs[4].out   = des_model(1'b1, K_C, vecs[4].core_in) ^ vecs[4].iv;

        i_Rst = 1'b0; i_fInit = 1'b0; i_fDec = 1'b0; i_Key = 64'd0; i_IV = 64'd0;
        i_fInValid = 1'b0; i_InBlk = 64'd0; i_fOutReady = 1'b0;
        i_Des_fDone = 1'b0; i_Des_Text = 64'd0;
        #12;
        chk("rst_in_ready", o_fInReady, 64'd0);
        chk("rst_out_valid", o_fOutValid, 64'd0);
        chk("rst_busy", o_fBusy, 64'd0);
        chk("rst_out_blk", o_OutBlk, 64'd0);
        i_Rst = 1'b1;
        step();
        i_fInValid = 1'b1;
        #1;
        chk("no_key_in_ready", o_fInReady, 64'd0);
        step();
        chk("no_key_busy", o_fBusy, 64'd0);
        i_fInValid = 1'b0;

        for (int v = 0; v < 5; v++) begin
            do_init(vecs[v].dec, K_C, vecs[v].iv);
            run_block(vecs[v].blk, vecs[v].dec, K_C, vecs[v].core_in, vecs[v].out, 0, 1'b0);
            chk($sformatf("chain_v%0d", v), dut.chain_r, vecs[v].chain);
        end

        // Four-block encrypt stream with back-pressure on block 2.
        blks[0] = 64'h1111_2222_3333_4444;
        blks[1] = 64'h5555_6666_7777_8888;
        blks[2] = 64'h9999_AAAA_BBBB_CCCC;
        blks[3] = 64'hDDDD_EEEE_FFFF_0000;
        chain = 64'h0F1E_2D3C_4B5A_6978;
        do_init(1'b0, K_C, chain);
        for (int b = 0; b < 4; b++) begin
            ci = blks[b] ^ chain;
            ct = des_model(1'b0, K_C, ci);
            run_block(blks[b], 1'b0, K_C, ci, ct, (b == 2) ? 5 : 0, 1'b0);
            chain = ct;
        end
        chk("stream_chain", dut.chain_r, chain);

        // Init and valid together: init wins, block refused.
        i_fInValid = 1'b1;
        i_InBlk    = 64'h0BAD_0BAD_0BAD_0BAD;
        i_fInit    = 1'b1;
        i_fDec     = 1'b0;
        i_Key      = K_C;
        i_IV       = 64'h0000_0000_0000_0000;
        #1;
        chk("init_blocks_ready", o_fInReady, 64'd0);
        step();
        i_fInit    = 1'b0;
        i_fInValid = 1'b0;
        chk("init_no_accept", o_fBusy, 64'd0);
        chk("init_chain", dut.chain_r, 64'd0);

        // Init while waiting on the core is ignored.
        run_block(PT_C, 1'b0, K_C, PT_C, CT_C, 0, 1'b1);
        chk("wait_init_chain", dut.chain_r, CT_C);

        // Stray done while idle produces nothing.
        i_Des_fDone = 1'b1;
        i_Des_Text  = 64'h7777_7777_7777_7777;
        step();
        i_Des_fDone = 1'b0;
        chk("stray_no_out", o_fOutValid, 64'd0);
        chk("stray_busy", o_fBusy, 64'd0);
        chk("stray_out_blk", o_OutBlk, CT_C);

        // Reset in the middle of a block.
        i_InBlk    = 64'h2468_ACE0_1357_9BDF;
        i_fInValid = 1'b1;
        step();
        i_fInValid = 1'b0;
        step();
        i_Rst = 1'b0;
        #1;
        chk("mid_rst_busy", o_fBusy, 64'd0);
        chk("mid_rst_text", o_Des_Text, 64'd0);
        chk("mid_rst_key", o_Des_Key, 64'd0);
        chk("mid_rst_out", o_OutBlk, 64'd0);
        step();
        i_Rst = 1'b1;
        i_fInValid = 1'b1;
        i_Des_fDone = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("post_rst_ready", o_fInReady, 64'd0);
            step();
            i_Des_fDone = 1'b0;
            chk("post_rst_busy", o_fBusy, 64'd0);
            chk("post_rst_valid", o_fOutValid, 64'd0);
        end
        i_fInValid = 1'b0;
        do_init(1'b0, K_C, 64'd0);
        run_block(PT_C, 1'b0, K_C, PT_C, CT_C, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
